// File: rtl/dkong_dma_sequencer.sv
// dkong_dma_sequencer: single-channel memory-to-memory DMA for the Donkey Kong bus (slave window 7800h-780Fh).
// Define DMA_BURST_YIELD_EN to give the bus back to the CPU every BURST_LEN bytes.
package dkong_bus_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        rdn;
    logic        wrn;
    logic        inta;
  } Z80MasterBus;
  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
endpackage

module dkong_dma_sequencer
  import dkong_bus_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int BURST_LEN     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  Z80MasterBus s_ibus,
  output Z80SlaveBus  s_obus,
  output Z80MasterBus m_obus,
  input  Z80SlaveBus  m_ibus,
  input  logic        rdy,
  output logic        busrq,
  input  logic        busack,
  output logic        msel,
  output logic        busy,
  output logic        done
);
  typedef enum logic [3:0] {S_IDLE, S_REQ, S_RSET, S_RD, S_WSET, S_WR, S_NEXT, S_REL, S_YIELD} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_src, r_dst;
  logic [13:0] r_cnt;
  logic [7:0]  r_data, w_rdata;
  logic [3:0]  r_acc, w_reg;
  logic        r_pending, r_abort, r_done, r_wrn_d, r_rdn_d;
  logic        w_wr, w_rd_stat, w_run, w_acc_end, w_last, w_yield, w_unused;

  assign w_reg     = s_ibus.addr[3:0];
  assign w_wr      = ena & ~s_ibus.wrn & r_wrn_d;
  assign w_rd_stat = ena & s_ibus.rdn & ~r_rdn_d & (w_reg == 4'd9);
  assign w_run     = r_state != S_IDLE && r_state != S_REL;
  // the strobe counter freezes while the slave holds mwait low
  assign w_acc_end = r_acc == 4'(ACCESS_CYCLES - 1) && m_ibus.mwait;
  assign w_last    = r_cnt == 14'd1 || r_abort;
  assign busy      = r_pending | w_run;
  assign done      = r_done;
  assign busrq     = w_run && r_state != S_YIELD;
  assign msel      = busrq && r_state != S_REQ;

`ifdef DMA_BURST_YIELD_EN
  logic [15:0] r_burst;
  assign w_yield  = r_burst == 16'(BURST_LEN - 1);
  assign w_unused = ^{s_ibus.addr[15:4], s_ibus.inta};
`else
  assign w_yield  = 1'b0;
  assign w_unused = ^{s_ibus.addr[15:4], s_ibus.inta, BURST_LEN[0]};
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (r_pending & rdy) ? S_REQ : S_IDLE;
      S_REQ:   w_next = busack ? S_RSET : S_REQ;
      S_RSET:  w_next = S_RD;
      S_RD:    w_next = w_acc_end ? S_WSET : S_RD;
      S_WSET:  w_next = S_WR;
      S_WR:    w_next = w_acc_end ? S_NEXT : S_WR;
      S_NEXT:  w_next = w_last ? S_REL : w_yield ? S_YIELD : S_RSET;
      S_YIELD: w_next = (r_acc == 4'd1) ? S_REQ : S_YIELD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_acc     <= '0;
      r_pending <= 1'b0;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_wrn_d   <= 1'b1;
      r_rdn_d   <= 1'b1;
`ifdef DMA_BURST_YIELD_EN
      r_burst   <= '0;
`endif
    end else begin
      r_wrn_d <= s_ibus.wrn;
      r_rdn_d <= s_ibus.rdn;
      r_acc   <= (w_next != r_state) ? '0 : (r_state == S_YIELD || m_ibus.mwait) ? r_acc + 1'b1 : r_acc;
      if (r_state == S_RD && w_acc_end) r_data <= m_ibus.dslave;
      if (r_state == S_NEXT) begin
        r_src <= r_src + 1'b1;
        r_dst <= r_dst + 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
`ifdef DMA_BURST_YIELD_EN
      if (r_state == S_NEXT) r_burst <= (w_yield | w_last) ? '0 : r_burst + 1'b1;
`endif
      if (r_state == S_IDLE && w_next == S_REQ) r_pending <= 1'b0;
      if (w_rd_stat) r_done <= 1'b0;
      if (r_state == S_NEXT && w_next == S_REL) r_done <= 1'b1;
      if (r_state == S_REL) r_abort <= 1'b0;
      if (w_wr && !busy)
        case (w_reg)
          4'd0:    r_src[7:0]  <= s_ibus.dmaster;
          4'd1:    r_src[15:8] <= s_ibus.dmaster;
          4'd2:    r_dst[7:0]  <= s_ibus.dmaster;
          4'd3:    r_dst[15:8] <= s_ibus.dmaster;
          4'd4:    r_cnt[7:0]  <= s_ibus.dmaster;
          4'd5:    r_cnt[13:8] <= s_ibus.dmaster[5:0];
          default: ;
        endcase
      // ABORT outranks START; a running transfer only latches it
      if (w_wr && w_reg == 4'd8) begin
        if (s_ibus.dmaster[1]) begin
          if (w_run) r_abort <= 1'b1;
          else       r_pending <= 1'b0;
        end else if (s_ibus.dmaster[0] && !busy) begin
          if (r_cnt == 14'd0) r_done <= 1'b1;
          else begin
            r_pending <= 1'b1;
            r_done    <= 1'b0;
          end
        end
      end
    end

  always_comb begin
    w_rdata = 8'h00;
    case (w_reg)
      4'd0:    w_rdata = r_src[7:0];
      4'd1:    w_rdata = r_src[15:8];
      4'd2:    w_rdata = r_dst[7:0];
      4'd3:    w_rdata = r_dst[15:8];
      4'd4:    w_rdata = r_cnt[7:0];
      4'd5:    w_rdata = {2'b00, r_cnt[13:8]};
      4'd9:    w_rdata = {6'd0, r_done, busy};
      default: w_rdata = 8'h00;
    endcase
  end

  always_comb begin
    m_obus         = '0;
    m_obus.addr    = msel ? ((r_state == S_WSET || r_state == S_WR) ? r_dst : r_src) : 16'h0000;
    m_obus.dmaster = r_data;
    m_obus.rdn     = r_state != S_RD;
    m_obus.wrn     = r_state != S_WR;
    m_obus.inta    = 1'b1;
    s_obus.dslave  = (ena & ~s_ibus.rdn) ? w_rdata : 8'h00;
    s_obus.mwait   = 1'b1;
  end
endmodule

// File: tb/tb_dkong_dma_sequencer.sv
// tb_dkong_dma_sequencer: scoreboard bench; a byte-copy reference model predicts every bus read and write.
`timescale 1ns/1ps
module tb_dkong_dma_sequencer;
  import dkong_bus_pkg::*;
  localparam int AC = 2, BL = 16, PER_BYTE = 2 * (1 + AC) + 1;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, rdy = 1'b1, busack = 1'b0;
  logic busrq, msel, busy, done;
  Z80MasterBus s_ibus, m_obus;
  Z80SlaveBus  s_obus, m_ibus;
  logic [7:0]  mem [65536];
  logic [7:0]  ref_mem [65536];
  logic [15:0] rd_q [$];
  logic [23:0] wr_q [$];
  int tests = 0, fails = 0, cyc = 0;
  int wait_cnt = 0, dir_wait = 0, ack_dly = 0, ack_cnt = 0;
  int tenures = 0, rd_starts = 0, wr_seen = 0, rd_len = 0, rd_run = 0, last_rd_cyc = -1;
  bit sb_en = 1, chk_timing = 0, rand_wait = 0;
  logic prev_rdn = 1'b1, prev_wrn = 1'b1, prev_busrq = 1'b0;

  dkong_dma_sequencer #(.ACCESS_CYCLES(AC), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .ena(ena), .s_ibus(s_ibus), .s_obus(s_obus),
    .m_obus(m_obus), .m_ibus(m_ibus), .rdy(rdy), .busrq(busrq),
    .busack(busack), .msel(msel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign m_ibus = {(wait_cnt != 0) ? 8'hEE : mem[m_obus.addr], wait_cnt == 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (sb_en && msel && !m_obus.wrn) mem[m_obus.addr] <= m_obus.dmaster;

  always @(negedge clk) begin
    if (!busrq) begin
      busack = 1'b0;
      ack_cnt = 0;
    end else if (!busack) begin
      ack_cnt++;
      if (ack_cnt >= ack_dly) busack = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [15:0] ea;
    logic [23:0] ew;
    if (wait_cnt > 0) wait_cnt--;
    if (msel) check("strobe_overlap", m_obus.rdn | m_obus.wrn, 1);
    if (busrq && !prev_busrq) tenures++;
    if (!m_obus.rdn && prev_rdn) begin
      rd_starts++;
      if (chk_timing && last_rd_cyc >= 0) check("byte_period", cyc - last_rd_cyc, PER_BYTE);
      last_rd_cyc = cyc;
      if (sb_en) begin
        check("rd_expected", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) begin
          ea = rd_q.pop_front();
          check("rd_addr", m_obus.addr, ea);
        end
      end
      if (dir_wait > 0) begin
        wait_cnt = dir_wait;
        dir_wait = 0;
      end else if (rand_wait && $urandom_range(0, 3) == 0) wait_cnt = $urandom_range(1, 3);
    end
    if (!m_obus.rdn) rd_run++;
    else if (!prev_rdn) begin
      rd_len = rd_run;
      rd_run = 0;
    end
    if (!m_obus.wrn && prev_wrn) begin
      wr_seen++;
      if (sb_en) begin
        check("wr_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          ew = wr_q.pop_front();
          check("wr_addr", m_obus.addr, ew[23:8]);
          check("wr_data", m_obus.dmaster, ew[7:0]);
        end
      end
      if (rand_wait && $urandom_range(0, 3) == 0) wait_cnt = $urandom_range(1, 3);
    end
    prev_rdn = m_obus.rdn;
    prev_wrn = m_obus.wrn;
    prev_busrq = busrq;
  end

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    ena = 1'b1; s_ibus.addr = {12'h780, a}; s_ibus.dmaster = d; s_ibus.wrn = 1'b0;
    @(negedge clk);
    ena = 1'b0; s_ibus.wrn = 1'b1;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    ena = 1'b1; s_ibus.addr = {12'h780, a}; s_ibus.rdn = 1'b0;
    @(negedge clk);
    d = s_obus.dslave; s_ibus.rdn = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  // reference: the transfer is a sequential byte copy, so overlapping windows behave like memmove-forward
  task automatic issue(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] cnt, input int nexp);
    for (int i = 0; i < nexp; i++) begin
      logic [15:0] s, d;
      s = src + 16'(i);
      d = dst + 16'(i);
      rd_q.push_back(s);
      ref_mem[d] = ref_mem[s];
      wr_q.push_back({d, ref_mem[d]});
    end
    cpu_wr(4'd0, src[7:0]); cpu_wr(4'd1, src[15:8]);
    cpu_wr(4'd2, dst[7:0]); cpu_wr(4'd3, dst[15:8]);
    cpu_wr(4'd4, cnt[7:0]); cpu_wr(4'd5, cnt[15:8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rv;
    logic [15:0] src;
    int t0, b0, n;
    s_ibus = '0; s_ibus.rdn = 1'b1; s_ibus.wrn = 1'b1; s_ibus.inta = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check("rst_busrq", busrq, 0); check("rst_msel", msel, 0);
    check("rst_busy", busy, 0);   check("rst_done", done, 0);
    check("rst_addr", m_obus.addr, 0); check("rst_dmaster", m_obus.dmaster, 0);
    check("rst_strobes", {m_obus.rdn, m_obus.wrn}, 2'b11); check("rst_dslave", s_obus.dslave, 0);
    rst = 1'b0;
    cpu_rd(4'd9, rv); check("rst_status", rv, 8'h00);

    ack_dly = 2; chk_timing = 1; last_rd_cyc = -1; t0 = tenures;
    issue(16'h6900, 16'h7000, 16'h0180, 384);
    cpu_wr(4'd8, 8'h01);
    check("start_busy", busy, 1); check("start_busrq_early", busrq, 0);
    @(negedge clk); check("ctrl_to_busrq", busrq, 1);
    repeat (20) @(negedge clk);
    cpu_wr(4'd0, 8'h55);
    wait_idle("bulk");
    chk_timing = 0;
    check("bulk_done", done, 1); check("bulk_wr_left", wr_q.size(), 0);
    check("bulk_tenures", tenures - t0, 1);
    cpu_rd(4'd0, rv); check("bulk_src_lo", rv, 8'h80);
    cpu_rd(4'd1, rv); check("bulk_src_hi", rv, 8'h6A);
    cpu_rd(4'd4, rv); check("bulk_cnt_lo", rv, 8'h00);
    cpu_rd(4'd9, rv); check("bulk_status", rv, 8'h02);
    cpu_rd(4'd9, rv); check("bulk_status_clr", rv, 8'h00);

    t0 = tenures;
    cpu_wr(4'd4, 8'h00); cpu_wr(4'd5, 8'h00); cpu_wr(4'd8, 8'h01);
    check("cnt0_done", done, 1);
    repeat (10) @(negedge clk);
    check("cnt0_no_busrq", tenures - t0, 0); check("cnt0_busy", busy, 0);
    cpu_rd(4'd9, rv);

    issue(16'hFFFE, 16'h1230, 16'd4, 4);
    cpu_wr(4'd8, 8'h01);
    wait_idle("wrap");
    check("wrap_rd_left", rd_q.size(), 0); check("wrap_wr_left", wr_q.size(), 0);
    cpu_rd(4'd1, rv); check("wrap_src_hi", rv, 8'h00);
    cpu_rd(4'd9, rv);

    issue(16'h2000, 16'h3000, 16'd10, 5);
    b0 = rd_starts; t0 = wr_seen; n = 0;
    cpu_wr(4'd8, 8'h01);
    while (rd_starts < b0 + 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_byte5", rd_starts - b0, 5);
    cpu_wr(4'd8, 8'h02);
    wait_idle("abort");
    check("abort_bytes", wr_seen - t0, 5); check("abort_wr_left", wr_q.size(), 0);
    check("abort_busrq", busrq, 0);
    cpu_rd(4'd9, rv); check("abort_status", rv, 8'h02);
    cpu_rd(4'd4, rv); check("abort_cnt_lo", rv, 8'h05);
    cpu_rd(4'd5, rv); check("abort_cnt_hi", rv, 8'h00);

    mem[16'h4000] = 8'h5A; ref_mem[16'h4000] = 8'h5A;
    issue(16'h4000, 16'h4100, 16'd1, 1);
    dir_wait = 3;
    cpu_wr(4'd8, 8'h01);
    wait_idle("mwait");
    check("mwait_rd_len", rd_len, AC + 3); check("mwait_wr_left", wr_q.size(), 0);
    check("mwait_mem", mem[16'h4100], 8'h5A);
    cpu_rd(4'd9, rv);

    sb_en = 0;
    issue(16'h5000, 16'h5100, 16'd8, 0);
    cpu_wr(4'd8, 8'h01);
    n = 0;
    while (m_obus.wrn && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach_wr", m_obus.wrn, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_wrn", m_obus.wrn, 1); check("rst_mid_msel", msel, 0);
    check("rst_mid_busrq", busrq, 0); check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", m_obus.addr, 0);
    @(negedge clk); rst = 1'b0; sb_en = 1;
    check("rst_mid_done", done, 0);

    rand_wait = 1;
    for (int k = 0; k < 12; k++) begin
      src = 16'($urandom);
      n = $urandom_range(1, 20);
      ack_dly = $urandom_range(0, 3);
      rdy = 1'($urandom_range(0, 1));
      issue(src, 16'($urandom), 16'(n), n);
      cpu_wr(4'd8, 8'h01);
      if (!rdy) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
        check("rdy_hold_busrq", busrq, 0);
        check("rdy_hold_busy", busy, 1);
        rdy = 1'b1;
      end
      wait_idle("rand");
      check("rand_done", done, 1); check("rand_wr_left", wr_q.size(), 0);
      cpu_rd(4'd9, rv); check("rand_status", rv, 8'h02);
      cpu_rd(4'd9, rv); check("rand_status_clr", rv, 8'h00);
    end
    rand_wait = 0;

    t0 = tenures; ack_dly = 1;
    issue(16'h6000, 16'h6800, 16'd32, 32);
    cpu_wr(4'd8, 8'h01);
    wait_idle("burst");
    check("burst_wr_left", wr_q.size(), 0);
`ifdef DMA_BURST_YIELD_EN
    check("burst_tenures", tenures - t0, 2);
`else
    check("burst_tenures", tenures - t0, 1);
`endif
    check("final_rd_left", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
